// File: rtl/seq_divider64_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_divider_pkg;

    localparam int DIV_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } div_state_t;

    // Magnitude of a full-width operand; the most negative value wraps to itself,
    // which the unsigned magnitude datapath then reads as 2**(DIV_WIDTH-1).
    function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] v,
                                                     input logic                 sgn);
        return (sgn && v[DIV_WIDTH-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/seq_divider64_div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract divisor.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic [WIDTH-1:0] next_quo
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Trial subtraction at WIDTH+1 bits; a set top bit means the divisor did not fit.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        if (diff[WIDTH]) begin
            next_rem = shifted[WIDTH-1:0];
            next_quo = {quo[WIDTH-2:0], 1'b0};
        end else begin
            next_rem = diff[WIDTH-1:0];
            next_quo = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/seq_divider64.sv
// Radix-2 restoring UDIV/SDIV with ARM64 divide-by-zero and overflow results.
// Latency: done WIDTH+1 edges after start (2 edges on early exit when SEQ_DIVIDER_EARLY_TERM_EN is defined).
// Backpressure: start is ignored while busy; flush squashes the in-flight op without done.
module seq_divider64
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem, quo, dvs_mag, dvd_orig;
    logic [WIDTH-1:0] step_rem, step_quo;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             q_neg, r_neg, dvs_zero, short_cut;
    logic             early_exit, last_iter, accept;

    assign a_mag     = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign b_mag     = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    assign accept    = start && !flush;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign busy      = (state != IDLE);

`ifdef SEQ_DIVIDER_EARLY_TERM_EN
    // First CALC cycle: quo still holds |dividend|, so a zero or oversized divisor is known here.
    assign early_exit = (state == CALC) && (cnt == '0) && (dvs_zero || (dvs_mag > quo));
`else
    assign early_exit = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvs_mag),
        .next_rem (step_rem),
        .next_quo (step_quo)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state selection; flush always returns a busy divider to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC: begin
                if (flush)                        state_nxt = IDLE;
                else if (early_exit || last_iter) state_nxt = FIN;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            dvs_mag     <= '0;
            dvd_orig    <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dvs_zero    <= 1'b0;
            short_cut   <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    dvd_orig  <= dividend;
                    quo       <= a_mag;
                    dvs_mag   <= b_mag;
                    rem       <= '0;
                    cnt       <= '0;
                    q_neg     <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    r_neg     <= is_signed & dividend[WIDTH-1];
                    dvs_zero  <= (divisor == '0);
                    short_cut <= 1'b0;
                end
                CALC: if (!flush) begin
                    if (early_exit) begin
                        short_cut <= 1'b1;
                    end else begin
                        rem <= step_rem;
                        quo <= step_quo;
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                FIN: if (!flush) begin
                    done        <= 1'b1;
                    div_by_zero <= dvs_zero;
                    // Zero or oversized divisor: remainder is the untouched dividend.
                    if (dvs_zero || short_cut) begin
                        quotient  <= '0;
                        remainder <= dvd_orig;
                    end else begin
                        quotient  <= q_neg ? -quo : quo;
                        remainder <= r_neg ? -rem : rem;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider64.sv
// Scoreboard bench for seq_divider64: directed UDIV/SDIV vectors, flush, reset abort, back-to-back.
// Latency: expects done 65 cycles after the start edge (2 on early exit when the macro is defined).
// Backpressure: checks that start while busy is ignored and start in the done cycle is accepted.
module tb_seq_divider64;

    localparam int W         = 64;
    localparam int LAT_FULL  = 65;
`ifdef SEQ_DIVIDER_EARLY_TERM_EN
    localparam int LAT_EARLY = 2;
`else
    localparam int LAT_EARLY = 65;
`endif

    logic         clk = 1'b0;
    logic         reset, start, flush, is_signed;
    logic [W-1:0] dividend, divisor, quotient, remainder;
    logic         busy, done, div_by_zero;

    seq_divider64 dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .flush       (flush),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic [31:0]  cyc;
    } exp_t;

    typedef struct packed {
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         early;
    } vec_t;

    exp_t         sb[$];
    exp_t         mon_e;
    vec_t         vecs[10];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           done_seen = 0;
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;
    logic         last_dz = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_seen++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d want no done", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("quotient",     quotient,         mon_e.q);
                check("remainder",    remainder,        mon_e.r);
                check("div_by_zero",  W'(div_by_zero),  W'(mon_e.dz));
                check("done_cycle",   W'(cyc),          W'(mon_e.cyc));
                check("busy_at_done", W'(busy),         W'(0));
                last_q  = mon_e.q;
                last_r  = mon_e.r;
                last_dz = mon_e.dz;
            end
        end
    end

    // Drive one request from a negedge; operands are scrambled after the start edge.
    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r, input logic dz,
                         input logic early, input logic expect_done);
        exp_t e;
        start     = 1'b1;
        is_signed = s;
        dividend  = a;
        divisor   = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = {$urandom, $urandom};
        divisor  = {$urandom, $urandom};
        if (expect_done) begin
            e.q   = q;
            e.r   = r;
            e.dz  = dz;
            e.cyc = cyc + (early ? LAT_EARLY : LAT_FULL);
            sb.push_back(e);
        end
        check("busy_after_start", W'(busy), W'(1));
    endtask

    // Wait for all expected results; ends on a negedge.
    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic stray_start();
        @(negedge clk);
        start     = 1'b1;
        is_signed = 1'b1;
        dividend  = {$urandom, $urandom};
        divisor   = 64'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        int seen_before;
        int n;

        reset = 1'b1; start = 1'b0; flush = 1'b0; is_signed = 1'b0;
        dividend = '0; divisor = '0;

        // s, a, b, q, r, dz, early
        vecs[0] = '{1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
                    64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9,
                    64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'h8000_0000_0000_0000, 64'd0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 64'h1234, 64'd0, 64'd0, 64'h1234, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd9,
                    64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0,
                    64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 64'd7, 64'd7, 64'd1, 64'd0, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE,
                    64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};

        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_busy",      W'(busy),        W'(0));
        check("rst_done",      W'(done),        W'(0));
        check("rst_quotient",  quotient,        W'(0));
        check("rst_remainder", remainder,       W'(0));
        check("rst_dz",        W'(div_by_zero), W'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            issue(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                  vecs[i].dz, vecs[i].early, 1'b1);
            wait_drain();
        end

        // Flush at cycle 20: no done, outputs keep the previous result.
        seen_before = done_seen;
        issue(1'b0, 64'd1000, 64'd3, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy",      W'(busy),        W'(0));
        check("flush_quotient",  quotient,        last_q);
        check("flush_remainder", remainder,       last_r);
        check("flush_dz",        W'(div_by_zero), W'(last_dz));

        // Flush together with start in IDLE: nothing accepted.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; is_signed = 1'b0;
        dividend = 64'd9; divisor = 64'd3;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", W'(busy), W'(0));

        // Reset at cycle 20 aborts and clears everything.
        @(negedge clk);
        issue(1'b0, 64'd1000, 64'd3, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy",      W'(busy),        W'(0));
        check("abort_done",      W'(done),        W'(0));
        check("abort_quotient",  quotient,        W'(0));
        check("abort_remainder", remainder,       W'(0));
        check("abort_dz",        W'(div_by_zero), W'(0));
        repeat (80) @(negedge clk);
        check("no_done_after_abort", W'(done_seen), W'(seen_before));

        // Back-to-back: stray starts while busy, second start in the done cycle.
        issue(1'b0, 64'd1000, 64'd3, 64'd333, 64'd1, 1'b0, 1'b0, 1'b1);
        repeat (3) begin
            repeat (8) @(negedge clk);
            stray_start();
        end
        n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL b2b_first_done_timeout: got done=%b want 1", done);
        end
        issue(1'b0, 64'hFFFF_FFFF, 64'h1_0000, 64'hFFFF, 64'hFFFF, 1'b0, 1'b0, 1'b1);
        stray_start();
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by time %0t want finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
